// File: rtl/flow_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : flow_pkt_fifo
// Brief    : Per-flow store-and-forward packet FIFO with show-ahead read port.
//            Packets become visible only once fully written; packets that do
//            not fit are dropped whole at their header. An optional statistics
//            block is enabled by defining FLOW_PKT_FIFO_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module flow_pkt_fifo #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_abort,
    input  logic             fifo_rdreq,
    output logic             fifo_empty,
    output logic [WIDTH-1:0] fifo_data,
    output logic             pkt_dropped
`ifdef FLOW_PKT_FIFO_STATS_EN
    ,
    output logic [15:0]      pkt_count,
    output logic [15:0]      drop_count
`endif
);

    localparam int                  PW      = DEPTH_LOG2 + 1;
    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0]       C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      rem_q, rem_d;
    logic            drop_q, drop_d;
    logic            mem_we;
    logic            commit;
    logic [PW-1:0]   used;
    logic [PW-1:0]   free;
    logic [7:0]      len;
    logic [WIDTH-1:0] mem [DEPTH];

    assign used        = wr_ptr_q - rd_ptr_q;
    assign free        = C_DEPTH - used;
    assign len         = wr_data[7:0];
    assign fifo_empty  = (rd_ptr_q == cm_ptr_q);
    assign fifo_data   = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign pkt_dropped = drop_q;

    // Write FSM, pointer updates and read pop; space is reserved at the header
    // using the pre-pop read pointer, so body words can never overflow.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        rem_d    = rem_q;
        drop_d   = 1'b0;
        mem_we   = 1'b0;
        commit   = 1'b0;
        rd_ptr_d = (fifo_rdreq && !fifo_empty) ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_valid) begin
                    if ((len == 8'd0) || ({{(PW-8){1'b0}}, len} > free)) begin
                        drop_d = 1'b1;
                        if (len > 8'd1) begin
                            rem_d   = len - 8'd1;
                            state_d = ST_DROP;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        rem_d    = len - 8'd1;
                        if (len == 8'd1) begin
                            cm_ptr_d = wr_ptr_q + 1'b1;
                            commit   = 1'b1;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (wr_abort) begin
                    wr_ptr_d = cm_ptr_q;
                    drop_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (wr_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rem_d    = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        cm_ptr_d = wr_ptr_q + 1'b1;
                        commit   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (wr_abort) begin
                    wr_ptr_d = cm_ptr_q;
                    state_d  = ST_IDLE;
                end else if (wr_valid) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state register; asynchronous clear hides any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
            rem_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rem_q    <= rem_d;
            drop_q   <= drop_d;
        end
    end

    // Packet storage; contents are not reset, visibility is governed by pointers.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

`ifdef FLOW_PKT_FIFO_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating commit and drop counters.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (commit && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule
`default_nettype wire
